// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        ADDIEX,
        ADDIWB,
        BRANCH,
        JUMP,
        JAL,
        TRAP
    } state_t;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MEM    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational control-word decode for the multi-cycle sequencer.
//   state     : current sequencer state
//   opcode    : opcode to use for state-dependent choices (latched by the top)
//   mem_ready : memory handshake, gates ir_write/pc_write in FETCH
//   ctrl_c    : full control word, every field 0 unless the state sets it
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output ctrl_t           ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state)
            FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.aluop     = ALUOP_ADD;
                ctrl_c.pc_src    = PCSRC_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMMSH;
                ctrl_c.aluop     = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.aluop     = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = REGDST_RT;
                ctrl_c.mem_to_reg = M2R_MEM;
            end
            MEMWR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.iord      = 1'b1;
            end
            EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.aluop     = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = REGDST_RD;
                ctrl_c.mem_to_reg = M2R_ALUOUT;
            end
            ADDIWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = REGDST_RT;
                ctrl_c.mem_to_reg = M2R_ALUOUT;
            end
            BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.aluop     = ALUOP_SUB;
                ctrl_c.pc_src    = PCSRC_ALUOUT;
                ctrl_c.branch_eq = (opcode == OP_BEQ);
                ctrl_c.branch_ne = (opcode == OP_BNE);
            end
            JUMP: begin
                ctrl_c.pc_src   = PCSRC_JUMP;
                ctrl_c.pc_write = 1'b1;
            end
            JAL: begin
                ctrl_c.pc_src     = PCSRC_JUMP;
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = REGDST_RA;
                ctrl_c.mem_to_reg = M2R_PC;
            end
            TRAP: begin
                ctrl_c.illegal = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: state register, opcode dispatch,
// retired-instruction counter and undefined-opcode trap.
//   clk, reset       : core clock, synchronous active-high reset
//   opcode           : instr[31:26], sampled in DECODE and MEMADR only
//   mem_ready        : memory handshake for FETCH, MEMRD, MEMWR
//   mem_read .. aluop: datapath selects and write enables
//   illegal          : held while trapped on an undefined opcode
//   instr_count      : retired instructions, wraps modulo 2^COUNT_W
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch_eq,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         aluop,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    state_t          state;
    state_t          state_next;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] dec_op;
    logic            retire;
    ctrl_t           ctrl_c;
    ctrl_t           gated_c;

    // Next-state dispatch; opcode is looked at only in DECODE and MEMADR.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:  if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_next = MEMADR;
                    OP_RTYPE:       state_next = EXEC;
                    OP_ADDIU:       state_next = ADDIEX;
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_J:           state_next = JUMP;
                    OP_JAL:         state_next = JAL;
                    default:        state_next = TRAP;
                endcase
            end
            MEMADR: state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_next = MEMWB;
            MEMWR:  if (mem_ready) state_next = FETCH;
            EXEC:   state_next = ALUWB;
            ADDIEX: state_next = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JAL: state_next = FETCH;
            TRAP:   state_next = TRAP;
            default: state_next = FETCH;
        endcase
    end

    // Only terminal states ever move into FETCH, so any entry retires one.
    assign retire = (state != FETCH) && (state_next == FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) op_q <= opcode;
            if (retire) instr_count <= instr_count + COUNT_W'(1);
        end
    end

    // BRANCH picks eq/ne from the opcode captured in DECODE, not the live bus.
    assign dec_op = ((state == DECODE) || (state == MEMADR)) ? opcode : op_q;

    ctrl_output_decode u_decode (
        .state     (state),
        .opcode    (dec_op),
        .mem_ready (mem_ready),
        .ctrl_c    (ctrl_c)
    );

    // Everything is silenced while reset is asserted.
    assign gated_c = reset ? '0 : ctrl_c;

    assign mem_read   = gated_c.mem_read;
    assign mem_write  = gated_c.mem_write;
    assign iord       = gated_c.iord;
    assign ir_write   = gated_c.ir_write;
    assign pc_write   = gated_c.pc_write;
    assign branch_eq  = gated_c.branch_eq;
    assign branch_ne  = gated_c.branch_ne;
    assign pc_src     = gated_c.pc_src;
    assign reg_write  = gated_c.reg_write;
    assign reg_dst    = gated_c.reg_dst;
    assign mem_to_reg = gated_c.mem_to_reg;
    assign alu_src_a  = gated_c.alu_src_a;
    assign alu_src_b  = gated_c.alu_src_b;
    assign aluop      = gated_c.aluop;
    assign illegal    = gated_c.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-derived control words.
module tb_multicycle_control;

    localparam int unsigned COUNT_W = 4;

    logic               clk;
    logic               reset;
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               mem_read, mem_write, iord, ir_write, pc_write;
    logic               branch_eq, branch_ne, reg_write, alu_src_a, illegal;
    logic [1:0]         pc_src, reg_dst, mem_to_reg, alu_src_b, aluop;
    logic [COUNT_W-1:0] instr_count;
    logic [19:0]        outs;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    multicycle_control #(.COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .branch_eq   (branch_eq),
        .branch_ne   (branch_ne),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .aluop       (aluop),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    assign outs = {mem_read, mem_write, iord, ir_write, pc_write, branch_eq,
                   branch_ne, pc_src, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, aluop, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack fields in the same order as outs.
    function automatic logic [19:0] ev(
        input logic mr, input logic mw, input logic io, input logic irw,
        input logic pcw, input logic beq, input logic bne,
        input logic [1:0] pcs, input logic rw, input logic [1:0] rd,
        input logic [1:0] m2r, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic ill);
        return {mr, mw, io, irw, pcw, beq, bne, pcs, rw, rd, m2r, asa, asb, aop, ill};
    endfunction

    function automatic logic [19:0] v_fetch(input logic r);
        return ev(1, 0, 0, r, r, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 2'b01, 0);
    endfunction

    localparam logic [19:0] V_DEC  = ev(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b11,2'b01,0);
    localparam logic [19:0] V_ADR  = ev(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b10,2'b01,0);
    localparam logic [19:0] V_MRD  = ev(1,0,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,2'b00,0);
    localparam logic [19:0] V_MWB  = ev(0,0,0,0,0,0,0,2'b00,1,2'b00,2'b01,0,2'b00,2'b00,0);
    localparam logic [19:0] V_MWR  = ev(0,1,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,2'b00,0);
    localparam logic [19:0] V_EX   = ev(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b00,0);
    localparam logic [19:0] V_AWB  = ev(0,0,0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,2'b00,0);
    localparam logic [19:0] V_IWB  = ev(0,0,0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,2'b00,0);
    localparam logic [19:0] V_BEQ  = ev(0,0,0,0,0,1,0,2'b01,0,2'b00,2'b00,1,2'b00,2'b10,0);
    localparam logic [19:0] V_BNE  = ev(0,0,0,0,0,0,1,2'b01,0,2'b00,2'b00,1,2'b00,2'b10,0);
    localparam logic [19:0] V_J    = ev(0,0,0,0,1,0,0,2'b10,0,2'b00,2'b00,0,2'b00,2'b00,0);
    localparam logic [19:0] V_JAL  = ev(0,0,0,0,1,0,0,2'b10,1,2'b10,2'b10,0,2'b00,2'b00,0);
    localparam logic [19:0] V_TRAP = ev(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,2'b00,1);

    localparam logic [5:0] JUNK = 6'b111111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check the control word, then advance one clock.
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [19:0] exp);
        opcode    = op;
        mem_ready = rdy;
        #1;
        check(tag, 32'(outs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        check(tag, 32'(instr_count), 32'(exp_cnt % (1 << COUNT_W)));
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = JUNK;
        #1;
        check(tag, 32'(outs), 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = JUNK;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_outs", 32'(outs), 32'h0);
        check("rst_cnt", 32'(instr_count), 32'h0);
        reset = 1'b0;

        // lw, no stalls: 5 cycles
        cyc("lw_fetch", JUNK, 1, v_fetch(1));
        cyc("lw_dec",   6'b100011, 1, V_DEC);
        cyc("lw_adr",   6'b100011, 1, V_ADR);
        cyc("lw_rd",    JUNK, 1, V_MRD);
        cyc("lw_wb",    JUNK, 1, V_MWB);
        exp_cnt++;
        chk_cnt("lw_cnt");

        // R-format with three FETCH stall cycles; mem_ready ignored in EXEC
        cyc("r_stall0", JUNK, 0, v_fetch(0));
        cyc("r_stall1", JUNK, 0, v_fetch(0));
        cyc("r_stall2", JUNK, 0, v_fetch(0));
        cyc("r_fetch",  JUNK, 1, v_fetch(1));
        cyc("r_dec",    6'b000000, 1, V_DEC);
        cyc("r_exec",   JUNK, 0, V_EX);
        cyc("r_wb",     JUNK, 1, V_AWB);
        exp_cnt++;
        chk_cnt("r_cnt");

        // addiu
        cyc("addi_fetch", JUNK, 1, v_fetch(1));
        cyc("addi_dec",   6'b001001, 1, V_DEC);
        cyc("addi_ex",    JUNK, 1, V_ADR);
        cyc("addi_wb",    JUNK, 1, V_IWB);
        exp_cnt++;
        chk_cnt("addi_cnt");

        // sw with one MEMWR stall; not counted until the write completes
        cyc("sw_fetch", JUNK, 1, v_fetch(1));
        cyc("sw_dec",   6'b101011, 1, V_DEC);
        cyc("sw_adr",   6'b101011, 1, V_ADR);
        cyc("sw_stall", JUNK, 0, V_MWR);
        chk_cnt("sw_stall_cnt");
        cyc("sw_wr",    JUNK, 1, V_MWR);
        exp_cnt++;
        chk_cnt("sw_cnt");

        // beq then bne; opcode bus is junk during BRANCH
        cyc("beq_fetch", JUNK, 1, v_fetch(1));
        cyc("beq_dec",   6'b000100, 1, V_DEC);
        cyc("beq_br",    JUNK, 1, V_BEQ);
        cyc("bne_fetch", JUNK, 1, v_fetch(1));
        cyc("bne_dec",   6'b000101, 1, V_DEC);
        cyc("bne_br",    6'b000100, 1, V_BNE);
        exp_cnt += 2;
        chk_cnt("br_cnt");

        // jal
        cyc("jal_fetch", JUNK, 1, v_fetch(1));
        cyc("jal_dec",   6'b000011, 1, V_DEC);
        cyc("jal_link",  JUNK, 1, V_JAL);
        exp_cnt++;
        chk_cnt("jal_cnt");

        // undefined opcode traps and holds
        cyc("trap_fetch", JUNK, 1, v_fetch(1));
        cyc("trap_dec",   JUNK, 1, V_DEC);
        for (int i = 0; i < 10; i++) cyc($sformatf("trap_hold%0d", i), 6'b000000, 1, V_TRAP);
        chk_cnt("trap_cnt");
        do_reset("trap_rst");
        chk_cnt("trap_rst_cnt");
        check("trap_rst_ill", 32'(illegal), 32'h0);

        // 16 jumps: counter reaches 15 then wraps to 0
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("j%0d_fetch", i), JUNK, 1, v_fetch(1));
            cyc($sformatf("j%0d_dec", i), 6'b000010, 1, V_DEC);
            cyc($sformatf("j%0d_jmp", i), JUNK, 1, V_J);
            exp_cnt++;
            if (i == 14) check("j_sat", 32'(instr_count), 32'd15);
        end
        check("j_wrap", 32'(instr_count), 32'd0);

        // reset during a stalled MEMRD aborts the lw
        exp_cnt = 0;
        cyc("ab_fetch", JUNK, 1, v_fetch(1));
        cyc("ab_dec",   6'b100011, 1, V_DEC);
        cyc("ab_adr",   6'b100011, 1, V_ADR);
        cyc("ab_rd",    JUNK, 0, V_MRD);
        do_reset("ab_rst");
        cyc("ab_after", JUNK, 0, v_fetch(0));
        check("ab_regw", 32'(reg_write), 32'h0);
        chk_cnt("ab_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
